alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (ops 0x1–0x9, 32-bit, ZERO flag) between two requesters, e.g. the execute stage and the address/branch unit.
- Each requester uses a valid/ready request channel and a valid/ack response channel.
- The block arbitrates round-robin, registers the operands that drive the ALU, and waits a fixed settle time for the ripple-carry and multiply paths.
- It then captures Y/ZERO into the winner's response registers.

---
 rtl/alu_share_arbiter_pkg.sv | 33 +++
 rtl/alu_share_arbiter_if.sv | 26 ++
 rtl/alu_share_arbiter_rr_arbiter_2.sv | 34 +++
 rtl/alu_share_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing block: opcodes, FSM states, data width.
// Stateless; no latency and no flow control of its own.
`ifndef PROJECT_DATA_WIDTH
`define PROJECT_DATA_WIDTH 32
`endif

package alu_share_arbiter_pkg;

    localparam int DATA_WIDTH = `PROJECT_DATA_WIDTH;

    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_MUL   = 6'h03;
    localparam logic [5:0] OP_SHR   = 6'h04;
    localparam logic [5:0] OP_SHL   = 6'h05;
    localparam logic [5:0] OP_AND   = 6'h06;
    localparam logic [5:0] OP_OR    = 6'h07;
    localparam logic [5:0] OP_NOR   = 6'h08;
    localparam logic [5:0] OP_SLT   = 6'h09;
    localparam logic [5:0] OPRN_MAX = OP_SLT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Six-bit compare also rejects anything with OPRN[5:4] set.
    function automatic logic oprn_ok(input logic [5:0] oprn);
        return (oprn >= OP_ADD) && (oprn <= OPRN_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request (valid/ready) and response (valid/ack) channels.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int DW = alu_share_arbiter_pkg::DATA_WIDTH
);
    logic          req_valid;
    logic [DW-1:0] req_op1;
    logic [DW-1:0] req_op2;
    logic [5:0]    req_oprn;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_y;
    logic          rsp_zero;
    logic          rsp_err;
    logic          rsp_ack;

    modport master (
        output req_valid, req_op1, req_op2, req_oprn, rsp_ack,
        input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_oprn, rsp_ack,
        output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant with a last-served pointer; grant is combinational, pointer updates on grant.
// No backpressure: any grant issued while enabled is taken as a completed handshake.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to "requester 1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant, registered operands, fixed settle time.
// Result valid EXEC_CYCLES edges after handshake (1 edge for a bad opcode); holds until ack, no grant until then.
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = alu_share_arbiter_pkg::DATA_WIDTH,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    req0,
    alu_share_arbiter_if.slave    req1,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [5:0]            alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_y,
    input  logic                  alu_zero
);

    import alu_share_arbiter_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t                state;
    logic                  owner;
    logic                  bad_op;
    logic [3:0]            cnt;
    logic [1:0]            valid;
    logic [1:0]            grant;
    logic [1:0]            ack;
    logic                  win;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;
    logic [5:0]            sel_oprn;

    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_zero;
    logic [1:0]            rsp_err;
    logic [DATA_WIDTH-1:0] rsp_y [2];

    assign valid = {req1.req_valid, req0.req_valid};
    assign ack   = {req1.rsp_ack, req0.rsp_ack};

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state == IDLE) && rst_n),
        .valid (valid),
        .grant (grant)
    );

    assign win      = grant[1];
    assign sel_op1  = win ? req1.req_op1  : req0.req_op1;
    assign sel_op2  = win ? req1.req_op2  : req0.req_op2;
    assign sel_oprn = win ? req1.req_oprn : req0.req_oprn;

    assign req0.req_ready = grant[0];
    assign req1.req_ready = grant[1];

    assign req0.rsp_valid = rsp_valid[0];
    assign req0.rsp_y     = rsp_y[0];
    assign req0.rsp_zero  = rsp_zero[0];
    assign req0.rsp_err   = rsp_err[0];
    assign req1.rsp_valid = rsp_valid[1];
    assign req1.rsp_y     = rsp_y[1];
    assign req1.rsp_zero  = rsp_zero[1];
    assign req1.rsp_err   = rsp_err[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            bad_op    <= 1'b0;
            cnt       <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_oprn  <= '0;
            rsp_valid <= 2'b00;
            rsp_zero  <= 2'b00;
            rsp_err   <= 2'b00;
            rsp_y[0]  <= '0;
            rsp_y[1]  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner  <= win;
                        cnt    <= CNT_LOAD;
                        bad_op <= !oprn_ok(sel_oprn);
                        state  <= EXEC;
                        if (oprn_ok(sel_oprn)) begin
                            alu_a    <= sel_op1;
                            alu_b    <= sel_op2;
                            alu_oprn <= sel_oprn;
                        end
                    end
                end
                EXEC: begin
                    // A rejected opcode spends a single cycle here, leaving the ALU inputs untouched.
                    if (bad_op) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_err[owner]   <= 1'b1;
                        rsp_zero[owner]  <= 1'b0;
                        rsp_y[owner]     <= '0;
                        state            <= RESP;
                    end else if (cnt == 4'd0) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_err[owner]   <= 1'b0;
                        rsp_zero[owner]  <= alu_zero;
                        rsp_y[owner]     <= alu_y;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (ack[owner]) begin
                        rsp_valid[owner] <= 1'b0;
                        rsp_err[owner]   <= 1'b0;
                        rsp_zero[owner]  <= 1'b0;
                        rsp_y[owner]     <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an attached reference ALU and a transaction-level model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int DW   = 32;
    localparam int EXEC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DW(DW)) rq0 ();
    alu_share_arbiter_if #(.DW(DW)) rq1 ();

    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic [5:0]    alu_oprn;
    logic          alu_zero;

    logic [1:0]    v = 2'b00;
    logic [1:0]    ack_man = 2'b00;
    logic          auto_ack = 1'b0;
    logic [DW-1:0] o1 [2];
    logic [DW-1:0] o2 [2];
    logic [5:0]    opn [2];

    assign rq0.req_valid = v[0];
    assign rq0.req_op1   = o1[0];
    assign rq0.req_op2   = o2[0];
    assign rq0.req_oprn  = opn[0];
    assign rq0.rsp_ack   = auto_ack ? rq0.rsp_valid : ack_man[0];
    assign rq1.req_valid = v[1];
    assign rq1.req_op1   = o1[1];
    assign rq1.req_op2   = o2[1];
    assign rq1.req_oprn  = opn[1];
    assign rq1.rsp_ack   = auto_ack ? rq1.rsp_valid : ack_man[1];

    logic [1:0]    rdy, rv, rz, re, ackv;
    logic [DW-1:0] ry [2];
    assign rdy   = {rq1.req_ready, rq0.req_ready};
    assign rv    = {rq1.rsp_valid, rq0.rsp_valid};
    assign rz    = {rq1.rsp_zero,  rq0.rsp_zero};
    assign re    = {rq1.rsp_err,   rq0.rsp_err};
    assign ackv  = {rq1.rsp_ack,   rq0.rsp_ack};
    assign ry[0] = rq0.rsp_y;
    assign ry[1] = rq1.rsp_y;

    alu_share_arbiter #(.DATA_WIDTH(DW), .EXEC_CYCLES(EXEC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (rq0),
        .req1     (rq1),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_oprn (alu_oprn),
        .alu_y    (alu_y),
        .alu_zero (alu_zero)
    );

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [5:0] op);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a * b;
            6'd4:    return a >> b;
            6'd5:    return a << b;
            6'd6:    return a & b;
            6'd7:    return a | b;
            6'd8:    return ~(a | b);
            6'd9:    return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_y    = alu_ref(alu_a, alu_b, alu_oprn);
        alu_zero = (alu_y == '0);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, winner by tie-break on last served.
    function automatic int pick(input logic [1:0] vv, input int last);
        if (vv == 2'b11) return (last == 1) ? 0 : 1;
        if (vv[0]) return 0;
        if (vv[1]) return 1;
        return -1;
    endfunction

    int            m_busy = 0, m_owner = 0, m_last = 1, m_rem = 0, m_on = 0, m_w = -1;
    logic          m_bad = 1'b0, m_zero = 1'b0;
    logic [DW-1:0] m_y = '0, m_a = '0, m_b = '0;
    logic [5:0]    m_op = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_rem = 0; m_on = 0;
            m_a = '0; m_b = '0; m_op = '0;
        end else if (m_busy == 0) begin
            m_w = pick(v, m_last);
            if (m_w >= 0) begin
                m_busy  = 1;
                m_owner = m_w;
                m_last  = m_w;
                m_bad   = !(opn[m_w] >= 6'd1 && opn[m_w] <= 6'd9);
                m_rem   = m_bad ? 1 : EXEC;
                if (!m_bad) begin
                    m_a = o1[m_w]; m_b = o2[m_w]; m_op = opn[m_w];
                end
                m_y    = m_bad ? '0 : alu_ref(o1[m_w], o2[m_w], opn[m_w]);
                m_zero = !m_bad && (m_y == '0);
            end
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_on = 1;
        end else if (ackv[m_owner]) begin
            m_on   = 0;
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), rdy[i],
                rst_n && (m_busy == 0) && (pick(v, m_last) == i));
            chk($sformatf("rsp_valid%0d", i), rv[i], (m_on != 0) && (m_owner == i));
            if ((m_on != 0) && (m_owner == i)) begin
                chk($sformatf("rsp_y%0d", i), ry[i], m_y);
                chk($sformatf("rsp_zero%0d", i), rz[i], m_zero);
                chk($sformatf("rsp_err%0d", i), re[i], m_bad);
            end
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_oprn", alu_oprn, m_op);
    end

    int grants[$];
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) if (v[i] && rdy[i]) grants.push_back(i);
        end
    end

    task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [5:0] op, output int waited);
        o1[i] = a; o2[i] = b; opn[i] = op; v[i] = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!rdy[i] && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!rdy[i]) chk("grant_wait", rdy[i], 1);
        @(posedge clk);
        #1 v[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rv[i]) break;
        end
        if (!rv[i]) chk("rsp_wait", rv[i], 1);
    endtask

    task automatic ack(input int i);
        ack_man[i] = 1'b1;
        @(posedge clk);
        #1 ack_man[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int n, w;

    initial begin
        for (int i = 0; i < 2; i++) begin
            o1[i] = '0; o2[i] = '0; opn[i] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid0", rv[0], 0);
        chk("rst_alu_oprn", alu_oprn, 0);
        do_reset();

        issue(0, 5, 3, OP_ADD, w);
        chk("add_ready_same_cycle", w, 0);
        wait_rsp(0, n);
        chk("add_latency", n, 2);
        chk("add_y", ry[0], 8);
        chk("add_zero", rz[0], 0);
        chk("add_err", re[0], 0);
        chk("add_rsp1_idle", rv[1], 0);
        ack(0);

        issue(1, 7, 7, OP_SUB, w);
        ack(1);  // lands while no response is valid and must be ignored
        wait_rsp(1, n);
        chk("sub_y", ry[1], 0);
        chk("sub_zero", rz[1], 1);
        ack(1);

        issue(0, 2, 9, OP_SLT, w);
        wait_rsp(0, n);
        chk("slt_y", ry[0], 1);
        ack(0);

        do_reset();
        grants.delete();
        auto_ack = 1'b1;
        fork
            begin
                int d;
                issue(0, 10, 3, OP_SUB, d);
                issue(0, 6, 5, OP_MUL, d);
                issue(0, 32'hF0, 4, OP_SHR, d);
            end
            begin
                int d;
                issue(1, 1, 4, OP_SHL, d);
                issue(1, 32'hC, 32'hA, OP_AND, d);
                issue(1, 32'hC, 32'hA, OP_NOR, d);
            end
        join
        repeat (6) @(posedge clk);
        #1 auto_ack = 1'b0;
        chk("contention_count", grants.size(), 6);
        for (int k = 0; k < 6 && k < grants.size(); k++)
            chk($sformatf("contention_order%0d", k), grants[k], k % 2);

        issue(0, 5, 3, OP_ADD, w);
        o1[1] = 32'hC; o2[1] = 32'h2; opn[1] = OP_OR; v[1] = 1'b1;
        wait_rsp(0, n);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid0", rv[0], 1);
            chk("bp_y0", ry[0], 8);
            chk("bp_ready1", rdy[1], 0);
        end
        ack_man[0] = 1'b1;
        @(posedge clk);
        #1 ack_man[0] = 1'b0;
        @(negedge clk);
        chk("bp_after_ack_ready1", rdy[1], 1);
        chk("bp_after_ack_valid0", rv[0], 0);
        @(posedge clk);
        #1 v[1] = 1'b0;
        wait_rsp(1, n);
        chk("bp_or_y", ry[1], 32'hE);
        ack(1);

        issue(0, 32'h55, 32'h66, 6'h0C, w);
        wait_rsp(0, n);
        chk("bad_latency", n, 1);
        chk("bad_err", re[0], 1);
        chk("bad_y", ry[0], 0);
        chk("bad_zero", rz[0], 0);
        chk("bad_alu_oprn_kept", alu_oprn, OP_OR);
        chk("bad_alu_a_kept", alu_a, 32'hC);
        ack(0);
        issue(1, 1, 1, 6'h31, w);
        wait_rsp(1, n);
        chk("bad_hi_bits_err", re[1], 1);
        ack(1);
        issue(0, 1, 1, 6'h00, w);
        wait_rsp(0, n);
        chk("bad_zero_op_err", re[0], 1);
        ack(0);

        issue(0, 9, 4, OP_SUB, w);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid0", rv[0], 0);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_alu_oprn", alu_oprn, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1, 20, 22, OP_ADD, w);
        wait_rsp(1, n);
        chk("post_rst_latency", n, 2);
        chk("post_rst_y", ry[1], 42);
        ack(1);
        grants.delete();
        auto_ack = 1'b1;
        fork
            begin
                int d;
                issue(0, 3, 3, OP_AND, d);
            end
            begin
                int d;
                issue(1, 3, 4, OP_OR, d);
            end
        join
        repeat (6) @(posedge clk);
        #1 auto_ack = 1'b0;
        chk("post_rst_contention_count", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("post_rst_first", grants[0], 0);
            chk("post_rst_second", grants[1], 1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
